// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
// Data wins contention unless fetch has already waited through STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDRESS_BITS-1:0] i_addr,
  output logic                    i_ready,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESS_BITS-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic                    grant_i;
  logic                    grant_d;
  logic                    starved;
  logic                    owner_d_q;
  logic                    we_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [CNT_W-1:0]        starve_q;
  logic                    i_valid_q;
  logic                    d_valid_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = ISSUE;
      ISSUE:   if (mem_ready) state_d = we_q ? IDLE : WAIT;
      WAIT:    if (mem_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grants are decided combinationally in IDLE and masked while reset is held
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (state_q == IDLE && reset) begin
      if (d_req && !(i_req && starved)) grant_d = 1'b1;
      else if (i_req)                   grant_i = 1'b1;
    end
    i_ready   = grant_i;
    d_ready   = grant_d;
    mem_req   = (state_q == ISSUE);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_valid   = i_valid_q;
    d_valid   = d_valid_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

  // Command latch, starvation counter and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      if (grant_d) begin
        owner_d_q <= 1'b1;
        we_q      <= d_we;
        addr_q    <= d_addr;
        wdata_q   <= d_wdata;
        if (!i_req)       starve_q <= '0;
        else if (!starved) starve_q <= starve_q + CNT_W'(1);
      end else if (grant_i) begin
        owner_d_q <= 1'b0;
        we_q      <= 1'b0;
        addr_q    <= i_addr;
        wdata_q   <= '0;
        starve_q  <= '0;
      end
      // Only the data side can write, so a write completion always belongs to data
      if (state_q == ISSUE && mem_ready && we_q) d_valid_q <= 1'b1;
      if (state_q == WAIT && mem_valid) begin
        if (owner_d_q) begin
          d_rdata_q <= mem_rdata;
          d_valid_q <= 1'b1;
        end else begin
          i_rdata_q <= mem_rdata;
          i_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, contention / reset sequences,
// then random traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned SL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, i_ready, i_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ready, d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ready, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         name;
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            stall;
    int            vdelay;
    logic [DW-1:0] mem_data;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
  } txn_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] ram     [4096];
  logic [DW-1:0] ref_ram [4096];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // One isolated transaction: request at cycle 0, optional stall in ISSUE, optional read delay
  task automatic run_txn(input txn_t t);
    int cyc;
    int lat;
    bit stray;
    bit is_wr;
    is_wr = t.is_d && t.we;
    if (t.is_d) begin
      d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
    end else begin
      i_req = 1'b1; i_addr = t.addr;
    end
    mem_ready = 1'b0; mem_valid = 1'b0;
    @(negedge clock);
    chk({t.name, " own ready"},   64'(t.is_d ? d_ready : i_ready), 64'(1));
    chk({t.name, " other ready"}, 64'(t.is_d ? i_ready : d_ready), 64'(0));
    @(posedge clock); #1;
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k <= t.stall; k++) begin
      mem_ready = (k == t.stall);
      mem_valid = 1'b1;
      mem_rdata = 32'hBAD0_0000 | DW'(k);
      @(negedge clock);
      chk($sformatf("%s issue%0d mem_req", t.name, k),  64'(mem_req),  64'(1));
      chk($sformatf("%s issue%0d mem_addr", t.name, k), 64'(mem_addr), 64'(t.addr));
      chk($sformatf("%s issue%0d mem_we", t.name, k),   64'(mem_we),   64'(is_wr));
      if (is_wr) chk($sformatf("%s issue%0d mem_wdata", t.name, k), 64'(mem_wdata), 64'(t.wdata));
      chk($sformatf("%s issue%0d readies", t.name, k), 64'({i_ready, d_ready}), 64'(0));
      @(posedge clock); #1;
    end
    mem_ready = 1'b0;
    cyc = t.stall + 2;
    lat = -1;
    stray = 1'b0;
    while (cyc < t.stall + 40 && lat < 0) begin
      mem_valid = !is_wr && (cyc == t.stall + 2 + t.vdelay);
      mem_rdata = mem_valid ? t.mem_data : 32'hBAD1_BAD1;
      @(negedge clock);
      if ((t.is_d ? i_valid : d_valid) || i_ready || d_ready) stray = 1'b1;
      if (t.is_d ? d_valid : i_valid) lat = cyc;
      @(posedge clock); #1;
      cyc++;
    end
    chk({t.name, " latency"}, 64'(lat), 64'(t.exp_lat));
    chk({t.name, " stray pulse"}, 64'(stray), 64'(0));
    if (!is_wr) chk({t.name, " rdata"}, 64'(t.is_d ? d_rdata : i_rdata), 64'(t.exp_rdata));
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tbl [5];
    txn_t post;
    bit   stray;
    int   got [10];
    int   exp_g [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   ng;
    bit   dual;

    tbl[0] = '{"fetch_rd",    1'b0, 1'b0, 12'h010, 32'h0,        0, 0, 32'h0000_0013, 3, 32'h0000_0013};
    tbl[1] = '{"sw",          1'b1, 1'b1, 12'h100, 32'hAAAA_A003, 0, 0, 32'h0,        2, 32'h0};
    tbl[2] = '{"lw",          1'b1, 1'b0, 12'h100, 32'h0,        0, 0, 32'hAAAA_A003, 3, 32'hAAAA_A003};
    tbl[3] = '{"sw_stall",    1'b1, 1'b1, 12'h0F0, 32'h5A5A_5A5A, 5, 0, 32'h0,        7, 32'h0};
    tbl[4] = '{"fetch_stall", 1'b0, 1'b0, 12'h020, 32'h0,        2, 3, 32'hDEAD_BEEF, 8, 32'hDEAD_BEEF};
    post   = '{"post_rst",    1'b0, 1'b0, 12'h030, 32'h0,        0, 1, 32'h0000_0055, 4, 32'h0000_0055};

    for (int a = 0; a < 4096; a++) begin
      ram[a]     = 32'h5000_0000 + DW'(a);
      ref_ram[a] = 32'h5000_0000 + DW'(a);
    end

    // Reset state, with a request pending that must not be granted
    idle_inputs();
    reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clock);
    chk("rst readies", 64'({i_ready, d_ready}), 64'(0));
    chk("rst valids",  64'({i_valid, d_valid}), 64'(0));
    chk("rst mem_req", 64'({mem_req, mem_we}),  64'(0));
    chk("rst rdata",   64'({i_rdata, d_rdata}), 64'(0));
    chk("rst mem_addr", 64'(mem_addr), 64'(0));
    @(posedge clock); #1;
    idle_inputs();
    reset = 1'b1;

    // Directed table; first row starts in the first cycle after reset release
    for (int r = 0; r < 5; r++) run_txn(tbl[r]);
    chk("d_rdata hold", 64'(d_rdata), 64'(32'hAAAA_A003));
    chk("i_rdata hold", 64'(i_rdata), 64'(32'hDEAD_BEEF));

    // Reset while waiting for read data, then a late mem_valid
    i_req = 1'b1; i_addr = 12'h044;
    @(posedge clock); #1;
    i_req = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0; i_req = 1'b1; d_req = 1'b1;
    #2 reset = 1'b0;
    @(negedge clock);
    chk("midrst readies",   64'({i_ready, d_ready}), 64'(0));
    chk("midrst valids",    64'({i_valid, d_valid}), 64'(0));
    chk("midrst mem_req",   64'({mem_req, mem_we}),  64'(0));
    chk("midrst i_rdata",   64'(i_rdata),   64'(0));
    chk("midrst d_rdata",   64'(d_rdata),   64'(0));
    chk("midrst mem_addr",  64'(mem_addr),  64'(0));
    chk("midrst mem_wdata", 64'(mem_wdata), 64'(0));
    @(posedge clock); #1;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    mem_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (i_valid || d_valid || mem_req || i_rdata != '0 || d_rdata != '0) stray = 1'b1;
      @(posedge clock); #1;
    end
    chk("late mem_valid ignored", 64'(stray), 64'(0));
    mem_valid = 1'b0;
    run_txn(post);

    // Contention: both sides request continuously
    do_reset();
    for (int k = 0; k < 10; k++) got[k] = 2;
    ng = 0; dual = 1'b0;
    i_req = 1'b1; i_addr = 12'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h300; d_wdata = 32'h0000_0001;
    mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(negedge clock);
      if (i_ready && d_ready) dual = 1'b1;
      if (d_ready)      begin got[ng] = 1; ng++; end
      else if (i_ready) begin got[ng] = 0; ng++; end
      @(posedge clock); #1;
    end
    for (int k = 0; k < 10; k++) chk($sformatf("grant order %0d (1=D 0=I)", k), 64'(got[k]), 64'(exp_g[k]));
    chk("dual ready", 64'(dual), 64'(0));

    // Randomised traffic against the transaction-level model
    do_reset();
    begin
      bit ip = 1'b0, dp = 1'b0;
      bit m_busy = 1'b0, m_side = 1'b0, m_we = 1'b0, m_acc = 1'b0;
      logic [AW-1:0] m_addr = '0;
      logic [DW-1:0] m_wdata = '0;
      int unsigned m_starve = 0;
      bit m_iv = 1'b0, m_dv = 1'b0;
      logic [DW-1:0] m_ird = '0, m_drd = '0;
      bit r_pend = 1'b0;
      logic [AW-1:0] r_addr = '0;
      bit e_ir, e_dr;
      for (int c = 0; c < 4000; c++) begin
        if (!ip && $urandom_range(0, 9) < 7) begin
          ip = 1'b1; i_addr = AW'($urandom_range(0, 15));
        end
        if (!dp && $urandom_range(0, 9) < 7) begin
          dp = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = AW'($urandom_range(0, 15)); d_wdata = DW'($urandom);
        end
        i_req = ip; d_req = dp;
        mem_ready = ($urandom_range(0, 3) != 0);
        mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = (mem_valid && r_pend) ? ram[r_addr] : DW'($urandom);
        @(negedge clock);
        e_ir = 1'b0; e_dr = 1'b0;
        if (!m_busy) begin
          if (d_req && !(i_req && m_starve == SL)) e_dr = 1'b1;
          else if (i_req)                         e_ir = 1'b1;
        end
        chk("rnd i_ready", 64'(i_ready), 64'(e_ir));
        chk("rnd d_ready", 64'(d_ready), 64'(e_dr));
        chk("rnd mem_req", 64'(mem_req), 64'(m_busy && !m_acc));
        chk("rnd i_valid", 64'(i_valid), 64'(m_iv));
        chk("rnd d_valid", 64'(d_valid), 64'(m_dv));
        chk("rnd i_rdata", 64'(i_rdata), 64'(m_ird));
        chk("rnd d_rdata", 64'(d_rdata), 64'(m_drd));
        if (m_busy && !m_acc) begin
          chk("rnd mem_addr", 64'(mem_addr), 64'(m_addr));
          chk("rnd mem_we",   64'(mem_we),   64'(m_we));
          if (m_we) chk("rnd mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        // Model: what the arbiter should do at this edge
        m_iv = 1'b0; m_dv = 1'b0;
        if (!m_busy) begin
          if (e_dr) begin
            m_busy = 1'b1; m_acc = 1'b0; m_side = 1'b1;
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
            m_starve = i_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
          end else if (e_ir) begin
            m_busy = 1'b1; m_acc = 1'b0; m_side = 1'b0;
            m_we = 1'b0; m_addr = i_addr; m_starve = 0;
          end
        end else if (!m_acc) begin
          if (mem_ready) begin
            if (m_we) begin
              ref_ram[m_addr] = m_wdata; m_busy = 1'b0; m_dv = 1'b1;
            end else m_acc = 1'b1;
          end
        end else if (mem_valid) begin
          if (m_side) begin m_drd = ref_ram[m_addr]; m_dv = 1'b1; end
          else        begin m_ird = ref_ram[m_addr]; m_iv = 1'b1; end
          m_busy = 1'b0;
        end
        // Memory device and requesters react to the actual port activity
        if (mem_req && mem_ready) begin
          if (mem_we) ram[mem_addr] = mem_wdata;
          else begin r_pend = 1'b1; r_addr = mem_addr; end
        end else if (r_pend && mem_valid) r_pend = 1'b0;
        if (i_ready) ip = 1'b0;
        if (d_ready) dp = 1'b0;
        @(posedge clock); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of memory data words.
REQ-002 Parameter ADDRESS_BITS, default 12: width of word addresses.
REQ-003 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while fetch is waiting.
REQ-004 Port clock, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low (0 = reset).
REQ-006 Ports i_req (input, 1) and i_addr (input, ADDRESS_BITS): instruction-fetch read request and its address.
REQ-007 Ports i_ready (output, 1), i_valid (output, 1) and i_rdata (output, DATA_WIDTH): fetch accept pulse, response pulse and read data.
REQ-008 Ports d_req (input, 1), d_we (input, 1), d_addr (input, ADDRESS_BITS) and d_wdata (input, DATA_WIDTH): data-side request, write enable, address and store data.
REQ-009 Ports d_ready (output, 1), d_valid (output, 1) and d_rdata (output, DATA_WIDTH): data accept pulse, completion pulse and load data.
REQ-010 Ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDRESS_BITS) and mem_wdata (output, DATA_WIDTH): single shared memory port command.
REQ-011 Ports mem_ready (input, 1), mem_valid (input, 1) and mem_rdata (input, DATA_WIDTH): memory command-accept, read-return strobe and read data.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-013 In IDLE, with any request pending, the block SHALL select a winner, register its address, write enable and store data, pulse that side's ready for one cycle (combinationally, in the same cycle), and go to ISSUE on the next edge.
REQ-014 Arbitration SHALL select the data side when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch SHALL win.
REQ-015 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on a data grant with i_req high; it SHALL clear on any fetch grant and on a data grant with i_req low.
REQ-016 Only one ready SHALL be high in any cycle, and no ready SHALL be high outside IDLE.
REQ-017 In ISSUE, the block SHALL hold mem_req=1 and stable latched mem_we, mem_addr and mem_wdata until the cycle mem_ready=1.
REQ-018 When a write is accepted (mem_ready=1), the block SHALL go to IDLE and pulse d_valid one cycle later.
REQ-019 When a read is accepted, the block SHALL go to WAIT.
REQ-020 In WAIT, on mem_valid=1 the block SHALL register mem_rdata into the owner's rdata, pulse the owner's valid on the next cycle, and return to IDLE.
REQ-021 mem_valid SHALL be ignored outside WAIT.
REQ-022 rdata outputs SHALL hold their last value until the next response of the same side.
REQ-023 Minimum read latency SHALL be 3 cycles (ready pulse to valid pulse) with mem_ready=1 in ISSUE and mem_valid on the following cycle.
REQ-024 Minimum write latency SHALL be 2 cycles.
REQ-025 A new grant SHALL be possible in the same cycle that the previous valid pulses, because the FSM is already in IDLE.
REQ-026 mem_we SHALL be 0 for every fetch transaction.
REQ-027 Requests SHALL NOT be queued: a requester holds req until it sees its ready pulse.

Reset
REQ-028 While reset=0, the FSM SHALL be IDLE, starve_cnt 0, and all outputs 0 (including rdata, mem_addr and mem_wdata), regardless of the current state.
REQ-029 An in-flight transaction aborted by reset SHALL produce no valid pulse, and a late mem_valid after reset SHALL be ignored.
REQ-030 The first grant SHALL be possible in the first cycle after reset rises.

Verification
REQ-031 Fetch read: i_req=1, i_addr=0x010, mem_ready=1, mem_valid one cycle later with rdata 0x00000013 -> i_ready on cycle 0, mem_req/mem_addr=0x010 on cycle 1, i_valid with i_rdata=0x00000013 on cycle 3.
REQ-032 Store then load (sw/lw): d_we=1, d_addr=0x100, d_wdata=0xAAAAA003 -> mem_we=1 with that data, d_valid 2 cycles after d_ready; then a d_we=0 read of 0x100 returning 0xAAAAA003 -> d_rdata=0xAAAAA003.
REQ-033 Contention: i_req and d_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I..., never two readies in one cycle.
REQ-034 Memory backpressure: mem_ready low for 5 cycles in ISSUE -> mem_req and mem_addr/mem_wdata stable for 6 cycles, no ready pulse meanwhile.
REQ-035 Reset mid-operation: reset=0 while in WAIT, then mem_valid=1 after release -> no i_valid/d_valid pulse, outputs 0, next request granted normally.
